lab_pio_gen: RTL and testbench

- Parametrised general-purpose I/O slave on the Avalon-MM bus; successor to the fixed 4-bit output-only PIO.
- Provides:
  - a DATA_WIDTH output register with atomic set/clear;
  - a synchronised input port;
  - per-bit edge capture with write-1-to-clear;
  - a maskable level interrupt to the CPU.
- Sits between the Nios bus fabric and board LEDs, switches and keys.

---
 rtl/lab_pio_gen.sv | 113 +++++++++++
 tb/tb_lab_pio_gen.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/lab_pio_gen.sv
// Parametrised Avalon-MM PIO slave: output register with set/clear, synchronised
// inputs, per-bit edge capture (write-1-to-clear) and a maskable level interrupt.
module lab_pio_gen #(
    parameter int          DATA_WIDTH  = 4,
    parameter logic [31:0] RESET_VALUE = 32'h0,
    parameter int          EDGE_TYPE   = 0,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  irq
);

    localparam logic [DATA_WIDTH-1:0] RV         = RESET_VALUE[DATA_WIDTH-1:0];
    localparam logic [2:0]            PRIME_DONE = 3'(SYNC_STAGES + 1);

    logic [DATA_WIDTH-1:0] sync_reg [SYNC_STAGES];
    logic [DATA_WIDTH-1:0] sync_q;
    logic [DATA_WIDTH-1:0] sync_d_reg;
    logic [DATA_WIDTH-1:0] out_reg;
    logic [DATA_WIDTH-1:0] irqmask_reg;
    logic [DATA_WIDTH-1:0] edgecap_reg;
    logic [DATA_WIDTH-1:0] edgecap_next;
    logic [DATA_WIDTH-1:0] edge_hit;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] clr_mask;
    logic [2:0]            prime_reg;
    logic                  prime_done;
    logic                  wr_en;
    logic                  unused_writedata;

    assign wr_en            = chipselect & ~write_n;
    assign wdata            = writedata[DATA_WIDTH-1:0];
    assign unused_writedata = &{1'b0, writedata};
    assign sync_q           = sync_reg[SYNC_STAGES-1];
    assign prime_done       = (prime_reg == PRIME_DONE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_reg[i] <= '0;
            end
            sync_d_reg <= '0;
            prime_reg  <= '0;
        end else begin
            sync_reg[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_reg[i] <= sync_reg[i-1];
            end
            sync_d_reg <= sync_q;
            if (!prime_done) begin
                prime_reg <= prime_reg + 3'd1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_edge
            if (EDGE_TYPE == 0) begin : g_rise
                assign edge_hit[gi] = sync_q[gi] & ~sync_d_reg[gi];
            end else if (EDGE_TYPE == 1) begin : g_fall
                assign edge_hit[gi] = ~sync_q[gi] & sync_d_reg[gi];
            end else begin : g_any
                assign edge_hit[gi] = sync_q[gi] ^ sync_d_reg[gi];
            end
        end
    endgenerate

    // A fresh edge is OR-ed in after the clear, so it survives a same-cycle W1C.
    assign clr_mask     = (wr_en && address == 3'd4) ? wdata : '0;
    assign edgecap_next = (edgecap_reg & ~clr_mask) | (prime_done ? edge_hit : '0);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_reg     <= RV;
            irqmask_reg <= '0;
            edgecap_reg <= '0;
        end else begin
            edgecap_reg <= edgecap_next;
            if (wr_en) begin
                case (address)
                    3'd0:    out_reg     <= wdata;
                    3'd1:    out_reg     <= out_reg | wdata;
                    3'd2:    out_reg     <= out_reg & ~wdata;
                    3'd3:    irqmask_reg <= wdata;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            3'd0:    readdata[DATA_WIDTH-1:0] = sync_q;
            3'd3:    readdata[DATA_WIDTH-1:0] = irqmask_reg;
            3'd4:    readdata[DATA_WIDTH-1:0] = edgecap_reg;
            3'd5:    readdata[DATA_WIDTH-1:0] = out_reg;
            default: readdata = '0;
        endcase
    end

    assign out_port = out_reg;
    assign irq      = |(edgecap_reg & irqmask_reg);

endmodule

// File: tb/tb_lab_pio_gen.sv
// Bench for lab_pio_gen: a rising-edge and an any-edge instance driven in parallel
// and compared every cycle against a sample-history reference model.
module tb_lab_pio_gen;

    localparam int S = 2;

    logic        clk = 1'b0;
    logic        reset_n, chipselect, write_n;
    logic [2:0]  address;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [31:0] rd0, rd1;
    logic [3:0]  out0, out1;
    logic        irq0, irq1;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: samples of in_port taken k edges ago, and per-instance registers.
    logic [3:0] s_hist [1:S+1];
    logic [3:0] out_m [2];
    logic [3:0] mask_m [2];
    logic [3:0] ec_m [2];
    int         since_rst;

    always #5 clk = ~clk;

    lab_pio_gen #(.DATA_WIDTH(4), .RESET_VALUE(32'h0), .EDGE_TYPE(0), .SYNC_STAGES(S)) dut0 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd0),
        .in_port(in_port), .out_port(out0), .irq(irq0));

    lab_pio_gen #(.DATA_WIDTH(4), .RESET_VALUE(32'h0), .EDGE_TYPE(2), .SYNC_STAGES(S)) dut1 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd1),
        .in_port(in_port), .out_port(out1), .irq(irq1));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_read(input int d, input logic [2:0] a);
        case (a)
            3'd0:    return {28'd0, s_hist[S]};
            3'd3:    return {28'd0, mask_m[d]};
            3'd4:    return {28'd0, ec_m[d]};
            3'd5:    return {28'd0, out_m[d]};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_edge(input bit rst, input bit wr, input logic [2:0] a,
                              input logic [31:0] wd, input logic [3:0] inp);
        logic [3:0] rise, fall, ev;
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                out_m[d] = 4'h0; mask_m[d] = 4'h0; ec_m[d] = 4'h0;
            end
            for (int k = 1; k <= S + 1; k++) s_hist[k] = 4'h0;
            since_rst = 0;
        end else begin
            rise = s_hist[S] & ~s_hist[S+1];
            fall = ~s_hist[S] & s_hist[S+1];
            for (int d = 0; d < 2; d++) begin
                ev = (d == 0) ? rise : (rise | fall);
                if (since_rst < S + 1) ev = 4'h0;
                if (wr) begin
                    case (a)
                        3'd0: out_m[d] = wd[3:0];
                        3'd1: out_m[d] = out_m[d] | wd[3:0];
                        3'd2: out_m[d] = out_m[d] & ~wd[3:0];
                        3'd3: mask_m[d] = wd[3:0];
                        3'd4: ec_m[d] = ec_m[d] & ~wd[3:0];
                        default: ;
                    endcase
                end
                ec_m[d] = ec_m[d] | ev;
            end
            for (int k = S + 1; k >= 2; k--) s_hist[k] = s_hist[k-1];
            s_hist[1] = inp;
            if (since_rst < 1000) since_rst++;
        end
    endtask

    // One bus cycle: drive, clock, update model, then compare both instances.
    task automatic step(input bit rst, input bit cs, input bit wn, input logic [2:0] a,
                        input logic [31:0] wd, input logic [3:0] inp);
        reset_n    = ~rst;
        chipselect = cs;
        write_n    = wn;
        address    = a;
        writedata  = wd;
        in_port    = inp;
        @(posedge clk);
        model_edge(rst, cs && !wn, a, wd, inp);
        @(negedge clk);
        chk("readdata0", rd0, exp_read(0, a));
        chk("readdata1", rd1, exp_read(1, a));
        chk("out_port0", {28'd0, out0}, {28'd0, out_m[0]});
        chk("out_port1", {28'd0, out1}, {28'd0, out_m[1]});
        chk("irq0", {31'd0, irq0}, {31'd0, |(ec_m[0] & mask_m[0])});
        chk("irq1", {31'd0, irq1}, {31'd0, |(ec_m[1] & mask_m[1])});
    endtask

    task automatic idle(input logic [2:0] a, input logic [3:0] inp, input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, a, 32'h0, inp);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] wd, input logic [3:0] inp);
        step(1'b0, 1'b1, 1'b0, a, wd, inp);
    endtask

    initial begin
        // Reset and DATA write
        step(1'b1, 1'b0, 1'b1, 3'd5, 32'h0, 4'h0);
        step(1'b1, 1'b0, 1'b1, 3'd5, 32'h0, 4'h0);
        chk("reset_out", {28'd0, out0}, 32'h0);
        chk("reset_irq", {31'd0, irq0}, 32'h0);
        wr(3'd0, 32'hA, 4'h0);
        chk("data_write", {28'd0, out0}, 32'hA);
        idle(3'd5, 4'h0, 1);
        chk("outrb", rd0, 32'h0000000A);

        // Set / clear / wide DATA write
        wr(3'd1, 32'h5, 4'h0);
        chk("outset", {28'd0, out0}, 32'hF);
        wr(3'd2, 32'h3, 4'h0);
        chk("outclr", {28'd0, out0}, 32'hC);
        wr(3'd0, 32'hFFFFFFF0, 4'h0);
        chk("data_trunc", {28'd0, out0}, 32'h0);

        // Input synchroniser latency
        idle(3'd0, 4'h6, 1);
        chk("sync_lat1", rd0, 32'h0);
        idle(3'd0, 4'h6, 1);
        chk("sync_lat2", rd0, 32'h6);
        idle(3'd0, 4'h6, 3);
        wr(3'd4, 32'hF, 4'h6);

        // Rising edge capture on bit0 with irq
        wr(3'd3, 32'h1, 4'h6);
        idle(3'd4, 4'h7, 2);
        chk("rise_early", rd0, 32'h0);
        idle(3'd4, 4'h7, 1);
        chk("rise_cap", rd0, 32'h1);
        chk("rise_irq", {31'd0, irq0}, 32'h1);
        idle(3'd4, 4'h6, 4);
        chk("fall_ignored", rd0, 32'h1);
        wr(3'd4, 32'h1, 4'h6);
        chk("w1c_clear", rd0, 32'h0);
        chk("w1c_irq", {31'd0, irq0}, 32'h0);

        // Edge beats same-cycle clear (any-edge instance), then unmask
        wr(3'd3, 32'h0, 4'h6);
        wr(3'd4, 32'hF, 4'h6);
        idle(3'd4, 4'h4, 2);
        wr(3'd4, 32'h2, 4'h4);
        chk("edge_wins", rd1, 32'h2);
        chk("masked_irq", {31'd0, irq1}, 32'h0);
        wr(3'd3, 32'h2, 4'h4);
        chk("unmask_irq", {31'd0, irq1}, 32'h1);

        // Priming: inputs high through reset never capture
        step(1'b1, 1'b0, 1'b1, 3'd4, 32'h0, 4'hF);
        step(1'b1, 1'b0, 1'b1, 3'd4, 32'h0, 4'hF);
        for (int i = 0; i < 20; i++) begin
            idle(3'd4, 4'hF, 1);
            chk("prime_ec0", rd0, 32'h0);
            chk("prime_ec1", rd1, 32'h0);
        end

        // Randomised traffic
        begin
            logic [3:0] inp;
            inp = 4'hF;
            for (int i = 0; i < 1500; i++) begin
                if ($urandom_range(0, 3) == 0) inp = inp ^ 4'($urandom_range(0, 15));
                step(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, inp);
            end
        end

        // Reset during capture overrides a concurrent write
        wr(3'd1, 32'h6, 4'h0);
        idle(3'd4, 4'h0, 4);
        wr(3'd4, 32'hF, 4'h0);
        idle(3'd4, 4'h3, 3);
        chk("pre_reset_ec", rd0, 32'h3);
        step(1'b1, 1'b1, 1'b0, 3'd0, 32'h5, 4'h3);
        chk("reset_mid_out", {28'd0, out0}, 32'h0);
        step(1'b1, 1'b0, 1'b1, 3'd4, 32'h0, 4'h3);
        chk("reset_mid_ec", rd0, 32'h0);
        idle(3'd4, 4'h3, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
